// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, parity modes and bit-vote helper.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_HIGH
   } rx_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the serial line, resets to the idle-high level.
module uart_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] ff_q;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ff_q <= 2'b11;
      else        ff_q <= {ff_q[0], d_i};

   assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with majority-vote bit sampling,
// optional parity and a single-entry output buffer with overrun reporting.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 baud_tick_i,
   input  logic                 rx_i,
   output logic [DATA_BITS-1:0] rx_data_o,
   output logic                 rx_valid_o,
   input  logic                 rx_ready_i,
   output logic                 parity_err_o,
   output logic                 frame_err_o,
   output logic                 overrun_o
);

   localparam int M  = OVERSAMPLE / 2;
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] T_M1   = TW'(M - 1);
   localparam logic [TW-1:0] T_M    = TW'(M);
   localparam logic [TW-1:0] T_P1   = TW'(M + 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
   localparam logic          PMODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

   logic                 rxs;
   rx_state_e            state_q, state_d;
   logic [TW-1:0]        tick_q, tick_d, cur;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
   logic [1:0]           samp_q, samp_d;
   logic                 pc_q, pc_d, valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
   logic                 bit_v, mid, last, done, accept, load;

   uart_rx_sync u_sync (.clk(clk), .rst_n(rst_n), .d_i(rx_i), .q_o(rxs));

   // tick_q is the index of the last tick consumed; cur is the index of this one
   assign cur    = (tick_q == T_LAST) ? '0 : tick_q + 1'b1;
   assign bit_v  = maj3(samp_q[0], samp_q[1], rxs);
   assign mid    = baud_tick_i && cur == T_P1;
   assign last   = baud_tick_i && cur == T_LAST;
   assign done   = state_q == S_STOP && mid;
   assign accept = valid_q && rx_ready_i;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= S_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         samp_q  <= '0;
         pc_q    <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         samp_q  <= samp_d;
         pc_q    <= pc_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      samp_d  = samp_q;
      pc_d    = pc_q;
      if (baud_tick_i && state_q != S_IDLE && state_q != S_WAIT_HIGH) begin
         tick_d = cur;
         if (cur == T_M1) samp_d[0] = rxs;
         if (cur == T_M)  samp_d[1] = rxs;
      end
      case (state_q)
         S_IDLE:
            if (baud_tick_i && !rxs) begin
               state_d = S_START;
               tick_d  = '0;
               bit_d   = '0;
            end
         S_START:
            if (mid && bit_v) begin
               state_d = S_IDLE;
               tick_d  = '0;
            end else if (last) state_d = S_DATA;
         S_DATA: begin
            if (mid) shift_d = {bit_v, shift_q[DATA_BITS-1:1]};
            if (last) begin
               bit_d = (bit_q == B_LAST) ? '0 : bit_q + 1'b1;
               if (bit_q == B_LAST) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (mid) pc_d = ((^shift_q) ^ bit_v) != PMODE;
            if (last) state_d = S_STOP;
         end
         S_STOP:
            if (mid) begin
               state_d = bit_v ? S_IDLE : S_WAIT_HIGH;
               tick_d  = '0;
            end
         S_WAIT_HIGH: if (rxs) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // a completed frame loads only into a free buffer or one being drained this cycle
   always_comb begin
      load    = done && (!valid_q || accept);
      data_d  = load ? shift_q : data_q;
      perr_d  = load ? pc_q : perr_q;
      ferr_d  = load ? !bit_v : ferr_q;
      valid_d = load || (valid_q && !accept);
      ovr_d   = done && !load;
   end

   assign rx_data_o    = data_q;
   assign rx_valid_o   = valid_q;
   assign parity_err_o = perr_q;
   assign frame_err_o  = ferr_q;
   assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: scoreboard bench over three receiver configurations (8N1, 8E1, 9N1 x8).
module tb_uart_rx_core;
   import uart_pkg::*;

   typedef struct {
      int         d;
      logic [8:0] data;
      logic       p;
      logic       stop;
      logic [8:0] ed;
      logic       ep;
      logic       ef;
   } vec_t;

   typedef struct {
      int         d;
      logic [8:0] data;
      logic       pe;
      logic       fe;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] tcnt = '0;
   logic       baud_tick;
   logic       rx [3];
   logic       rdy [3];
   logic       vld [3];
   logic       perr [3];
   logic       ferr [3];
   logic       ovr [3];
   logic [7:0] rd0, rd1;
   logic [8:0] rd2;
   logic [8:0] rdat [3];
   int         ocnt [3];
   int         chk = 0;
   int         err = 0;
   exp_t       sb [$];
   vec_t       tbl [12];

   always #5 clk = ~clk;
   always @(posedge clk) tcnt <= tcnt + 2'd1;
   assign baud_tick = tcnt == 2'd3;

   assign rdat[0] = {1'b0, rd0};
   assign rdat[1] = {1'b0, rd1};
   assign rdat[2] = rd2;

   uart_rx_core u0 (
      .clk(clk), .rst_n(rst_n), .baud_tick_i(baud_tick), .rx_i(rx[0]), .rx_data_o(rd0),
      .rx_valid_o(vld[0]), .rx_ready_i(rdy[0]), .parity_err_o(perr[0]), .frame_err_o(ferr[0]),
      .overrun_o(ovr[0])
   );

   uart_rx_core #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
      .clk(clk), .rst_n(rst_n), .baud_tick_i(baud_tick), .rx_i(rx[1]), .rx_data_o(rd1),
      .rx_valid_o(vld[1]), .rx_ready_i(rdy[1]), .parity_err_o(perr[1]), .frame_err_o(ferr[1]),
      .overrun_o(ovr[1])
   );

   uart_rx_core #(.DATA_BITS(9), .OVERSAMPLE(8)) u2 (
      .clk(clk), .rst_n(rst_n), .baud_tick_i(baud_tick), .rx_i(rx[2]), .rx_data_o(rd2),
      .rx_valid_o(vld[2]), .rx_ready_i(rdy[2]), .parity_err_o(perr[2]), .frame_err_o(ferr[2]),
      .overrun_o(ovr[2])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic wait_tick();
      @(posedge clk iff baud_tick);
      #1;
   endtask

   task automatic send_bit(input int d, input logic v);
      rx[d] = v;
      repeat ((d == 2) ? 8 : 16) wait_tick();
   endtask

   task automatic send_frame(input int d, input logic [8:0] data, input logic p, input logic stop);
      send_bit(d, 1'b0);
      for (int i = 0; i < ((d == 2) ? 9 : 8); i++) send_bit(d, data[i]);
      if (d == 1) send_bit(d, p);
      send_bit(d, stop);
      rx[d] = 1'b1;
      repeat ((d == 2) ? 16 : 32) wait_tick();
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) if (ovr[d]) ocnt[d]++;
      if (rst_n)
         for (int d = 0; d < 3; d++)
            if (vld[d] && rdy[d]) begin
               if (sb.size() == 0) begin
                  chk++;
                  err++;
                  $display("FAIL unexpected_frame dut=%0d actual=%0h expected=none", d, rdat[d]);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  check("frame_dut", d, e.d);
                  check("rx_data", 32'(rdat[d]), 32'(e.data));
                  check("parity_err", 32'(perr[d]), 32'(e.pe));
                  check("frame_err", 32'(ferr[d]), 32'(e.fe));
               end
            end
   end

   initial begin
      tbl[0]  = '{0, 9'h0A5, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b0};
      tbl[1]  = '{0, 9'h03C, 1'b0, 1'b0, 9'h03C, 1'b0, 1'b1};
      tbl[2]  = '{0, 9'h011, 1'b0, 1'b1, 9'h011, 1'b0, 1'b0};
      tbl[3]  = '{0, 9'h000, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0};
      tbl[4]  = '{0, 9'h0FF, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b0};
      tbl[5]  = '{1, 9'h007, 1'b0, 1'b1, 9'h007, 1'b1, 1'b0};
      tbl[6]  = '{1, 9'h007, 1'b1, 1'b1, 9'h007, 1'b0, 1'b0};
      tbl[7]  = '{1, 9'h0A5, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b0};
      tbl[8]  = '{1, 9'h03C, 1'b0, 1'b0, 9'h03C, 1'b0, 1'b1};
      tbl[9]  = '{2, 9'h1AB, 1'b0, 1'b1, 9'h1AB, 1'b0, 1'b0};
      tbl[10] = '{2, 9'h100, 1'b0, 1'b1, 9'h100, 1'b0, 1'b0};
      tbl[11] = '{2, 9'h0FE, 1'b0, 1'b0, 9'h0FE, 1'b0, 1'b1};
      for (int d = 0; d < 3; d++) begin
         rx[d] = 1'b1;
         rdy[d] = 1'b1;
         ocnt[d] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check("reset_data", 32'(rdat[d]), 0);
         check("reset_valid", 32'(vld[d]), 0);
         check("reset_flags", {perr[d], ferr[d], ovr[d]}, 0);
      end
      check("reset_state", 32'(u0.state_q), 32'(S_IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) wait_tick();

      for (int i = 0; i < 12; i++) begin
         sb.push_back('{tbl[i].d, tbl[i].ed, tbl[i].ep, tbl[i].ef});
         send_frame(tbl[i].d, tbl[i].data, tbl[i].p, tbl[i].stop);
      end

      // stop bit low, line held low: receiver must park in WAIT_HIGH without restarting
      sb.push_back('{0, 9'h03C, 1'b0, 1'b1});
      send_bit(0, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(0, (8'h3C >> i) & 8'h1);
      send_bit(0, 1'b0);
      repeat (48) wait_tick();
      check("wait_high_state", 32'(u0.state_q), 32'(S_WAIT_HIGH));
      rx[0] = 1'b1;
      repeat (2) wait_tick();
      check("wait_high_exit", 32'(u0.state_q), 32'(S_IDLE));
      sb.push_back('{0, 9'h011, 1'b0, 1'b0});
      send_frame(0, 9'h011, 1'b0, 1'b1);

      // glitch of three ticks is rejected at tick M+1
      rx[0] = 1'b0;
      repeat (3) wait_tick();
      check("glitch_start_seen", 32'(u0.state_q), 32'(S_START));
      rx[0] = 1'b1;
      repeat (7) wait_tick();
      check("glitch_rejected", 32'(u0.state_q), 32'(S_IDLE));
      check("glitch_no_valid", 32'(vld[0]), 0);
      repeat (32) wait_tick();

      // overrun: consumer stalled across two frames
      rdy[0] = 1'b0;
      send_frame(0, 9'h012, 1'b0, 1'b1);
      check("ovr_first_valid", 32'(vld[0]), 1);
      check("ovr_first_data", 32'(rdat[0]), 32'h12);
      check("ovr_none_yet", ocnt[0], 0);
      send_frame(0, 9'h034, 1'b0, 1'b1);
      check("ovr_held_data", 32'(rdat[0]), 32'h12);
      check("ovr_held_valid", 32'(vld[0]), 1);
      check("ovr_pulse_count", ocnt[0], 1);
      sb.push_back('{0, 9'h012, 1'b0, 1'b0});
      rdy[0] = 1'b1;
      @(posedge clk);
      #1;
      check("drain_valid_clear", 32'(vld[0]), 0);
      check("drain_data_hold", 32'(rdat[0]), 32'h12);

      // reset in the middle of the data bits of 0x55
      send_bit(0, 1'b0);
      send_bit(0, 1'b1);
      send_bit(0, 1'b0);
      send_bit(0, 1'b1);
      rx[0] = 1'b0;
      repeat (8) wait_tick();
      check("mid_data_state", 32'(u0.state_q), 32'(S_DATA));
      rst_n = 1'b0;
      #1;
      check("rst_data", 32'(rdat[0]), 0);
      check("rst_valid", 32'(vld[0]), 0);
      check("rst_flags", {perr[0], ferr[0], ovr[0]}, 0);
      check("rst_state", 32'(u0.state_q), 32'(S_IDLE));
      rx[0] = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (200) wait_tick();
      check("post_rst_idle", 32'(u0.state_q), 32'(S_IDLE));
      check("post_rst_no_valid", 32'(vld[0]), 0);

      check("scoreboard_empty", sb.size(), 0);
      check("ovr_total_u0", ocnt[0], 1);
      check("ovr_total_u1", ocnt[1], 0);
      check("ovr_total_u2", ocnt[2], 0);
      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
